sequenciador_ula: RTL and testbench
===================================

Name: sequenciador_ula

Overview:
- Control sequencer for the 8-bit ALU datapath.
- Collects operand A, operand B and the opcode through clean `enter` pulses, and supports reusing the previous result as the new operand A.
- Drives an external combinational ALU for single-cycle ops. Runs an internal iterative shift-add multiplier and restoring divider for multi-cycle ops.
- Sits between the debounced button/switch front end and the result display register.

Parameters:
- W, 8, datapath width in bits; the iteration counter is clog2(W)+1 bits wide.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- enter  in  1  clean one-cycle pulse: confirm the current entry
- reuso  in  1  clean one-cycle pulse: load the last result into A
- dado_in  in  W  operand switches
- op_in  in  3  opcode switches
- alu_res  in  W  result from the external combinational ALU
- alu_a  out  W  operand A register value, to the ALU
- alu_b  out  W  operand B register value, to the ALU
- alu_op  out  3  opcode register value, to the ALU
- resultado  out  W  result register
- estado  out  3  current state encoding, for LEDs and debug
- ocupado  out  1  high while the state is EXEC or ITERA
- pronto  out  1  one-cycle pulse on the first MOSTRA cycle
- erro_div0  out  1  division-by-zero flag

Behaviour:
- Reset (asynchronous, active-high): state ESPERA_A; A, B, op, resultado, iteration counter and all internal accumulators cleared to 0; pronto=0; erro_div0=0; ocupado=0.
- State encoding: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, EXEC=3, ITERA=4, MOSTRA=5. Codes 6 and 7 return to ESPERA_A on the next edge.
- ESPERA_A:
  - `reuso` → A <= resultado, go to ESPERA_B.
  - else `enter` → A <= dado_in, go to ESPERA_B.
  - `reuso` has priority when both pulses arrive in the same cycle.
- ESPERA_B: `enter` → B <= dado_in, go to ESPERA_OP. `reuso` is ignored.
- ESPERA_OP: `enter` → op <= op_in.
  - op_in 110 (mul) or 111 (div) → ITERA, counter <= 0, iterative unit initialised from A and B.
  - All other opcodes → EXEC.
- EXEC: exactly one cycle. resultado <= alu_res, go to MOSTRA.
  - Latency: `enter` captured at edge k → result visible after edge k+1.
- ITERA, mul (unsigned shift-add):
  - One partial-product step per edge for W edges.
  - resultado <= low W bits of A*B, written at edge k+W, where k is the edge that entered ITERA.
- ITERA, div (unsigned restoring division):
  - One quotient bit per edge for W edges.
  - resultado <= floor(A/B); the remainder is discarded.
  - If B==0 on entry: at the first ITERA edge, resultado <= all ones, erro_div0 <= 1, go to MOSTRA. No further iterations.
- MOSTRA:
  - Holds resultado. pronto=1 only on the first cycle.
  - `enter` → clear A, B, op and erro_div0, go to ESPERA_A.
  - `reuso` → A <= resultado, clear erro_div0, go to ESPERA_B. `reuso` has priority over `enter`.
- `enter` and `reuso` are ignored while ocupado=1; nothing is queued.
- alu_a, alu_b and alu_op reflect the registers continuously. alu_res is sampled only in EXEC.
- resultado changes only on EXEC/ITERA completion or reset. Entering new operands does not disturb the displayed result.
- Reset mid-ITERA: completion is aborted immediately, all state is cleared, and no pronto pulse is issued.

Test Plan:
- Basic add: enter A=5, enter B=3, enter op=000 → MOSTRA after 1 EXEC cycle; resultado=8, pronto pulses once, ocupado high for exactly 1 cycle.
- Multiply:
  - A=12, B=11, op=110 → ocupado high 8 cycles, then resultado=0x84.
  - Repeat with A=20, B=20 → resultado=0x90 (truncation check).
- Divide:
  - A=200, B=7, op=111 → resultado=28 after 8 cycles.
  - A=9, B=0 → resultado=0xFF and erro_div0=1 after 1 cycle; subsequent `enter` clears the flag.
- Reuse chain: 5+3=8, then `reuso` in MOSTRA, B=2, op=001 → resultado=6. Also pulse `reuso` and `enter` together in ESPERA_A → A takes resultado.
- Busy protection: pulse `enter` and `reuso` during ITERA of 255*255 → ignored; resultado=0x01, state sequence unchanged.
- Reset mid-ITERA at cycle 4: all outputs 0, estado=0, no pronto pulse; the next full sequence 7-2 (op=001) → resultado=5.

Source files
------------

// File: rtl/sequenciador_ula.sv
// Operand/opcode entry sequencer for the 8-bit ALU datapath.
// Single-cycle ops use the external ALU; mul/div run on an internal iterative unit.
module sequenciador_ula #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enter,
  input  logic         reuso,
  input  logic [W-1:0] dado_in,
  input  logic [2:0]   op_in,
  input  logic [W-1:0] alu_res,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic [W-1:0] resultado,
  output logic [2:0]   estado,
  output logic         ocupado,
  output logic         pronto,
  output logic         erro_div0
);

  localparam int CW = $clog2(W) + 1;

  localparam logic [2:0] ESPERA_A  = 3'd0;
  localparam logic [2:0] ESPERA_B  = 3'd1;
  localparam logic [2:0] ESPERA_OP = 3'd2;
  localparam logic [2:0] EXEC      = 3'd3;
  localparam logic [2:0] ITERA     = 3'd4;
  localparam logic [2:0] MOSTRA    = 3'd5;

  logic [2:0]    estado_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [2:0]    op_reg;
  logic [W-1:0]  resultado_reg;
  logic [CW-1:0] cnt_reg;
  logic          pronto_reg;
  logic          erro_reg;

  // acc_reg: product (mul) or partial remainder (div)
  // mc_reg : shifted multiplicand (mul) or dividend/quotient shifter (div)
  // mp_reg : multiplier shifter (mul only)
  logic [W-1:0]  acc_reg;
  logic [W-1:0]  mc_reg;
  logic [W-1:0]  mp_reg;

  logic [W-1:0]  mul_acc_next;
  logic [W-1:0]  mul_mc_next;
  logic [W-1:0]  mul_mp_next;
  logic [W:0]    rem_sh;
  logic          q_bit;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  quo_next;
  logic          is_div;
  logic          last_step;
  logic          div_by_zero;

  always_comb begin
    mul_acc_next = acc_reg + (mp_reg[0] ? mc_reg : '0);
    mul_mc_next  = mc_reg << 1;
    mul_mp_next  = mp_reg >> 1;
    rem_sh       = {acc_reg, mc_reg[W-1]};
    q_bit        = (rem_sh >= {1'b0, b_reg});
    // after a successful subtraction the remainder is below B, so W bits suffice
    rem_next     = q_bit ? (rem_sh[W-1:0] - b_reg) : rem_sh[W-1:0];
    quo_next     = {mc_reg[W-2:0], q_bit};
  end

  assign is_div      = op_reg[0];
  assign last_step   = (cnt_reg == CW'(W - 1));
  assign div_by_zero = is_div && (cnt_reg == '0) && (b_reg == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_reg    <= ESPERA_A;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      resultado_reg <= '0;
      cnt_reg       <= '0;
      pronto_reg    <= 1'b0;
      erro_reg      <= 1'b0;
      acc_reg       <= '0;
      mc_reg        <= '0;
      mp_reg        <= '0;
    end else begin
      pronto_reg <= 1'b0;
      case (estado_reg)
        ESPERA_A: begin
          if (reuso) begin
            a_reg      <= resultado_reg;
            estado_reg <= ESPERA_B;
          end else if (enter) begin
            a_reg      <= dado_in;
            estado_reg <= ESPERA_B;
          end
        end
        ESPERA_B: begin
          if (enter) begin
            b_reg      <= dado_in;
            estado_reg <= ESPERA_OP;
          end
        end
        ESPERA_OP: begin
          if (enter) begin
            op_reg <= op_in;
            if (op_in[2:1] == 2'b11) begin
              cnt_reg    <= '0;
              acc_reg    <= '0;
              mc_reg     <= a_reg;
              mp_reg     <= b_reg;
              estado_reg <= ITERA;
            end else begin
              estado_reg <= EXEC;
            end
          end
        end
        EXEC: begin
          resultado_reg <= alu_res;
          pronto_reg    <= 1'b1;
          estado_reg    <= MOSTRA;
        end
        ITERA: begin
          if (div_by_zero) begin
            resultado_reg <= '1;
            erro_reg      <= 1'b1;
            pronto_reg    <= 1'b1;
            estado_reg    <= MOSTRA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (is_div) begin
              acc_reg <= rem_next;
              mc_reg  <= quo_next;
            end else begin
              acc_reg <= mul_acc_next;
              mc_reg  <= mul_mc_next;
              mp_reg  <= mul_mp_next;
            end
            if (last_step) begin
              resultado_reg <= is_div ? quo_next : mul_acc_next;
              pronto_reg    <= 1'b1;
              estado_reg    <= MOSTRA;
            end
          end
        end
        MOSTRA: begin
          if (reuso) begin
            a_reg      <= resultado_reg;
            erro_reg   <= 1'b0;
            estado_reg <= ESPERA_B;
          end else if (enter) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            erro_reg   <= 1'b0;
            estado_reg <= ESPERA_A;
          end
        end
        default: estado_reg <= ESPERA_A;
      endcase
    end
  end

  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_op    = op_reg;
  assign resultado = resultado_reg;
  assign estado    = estado_reg;
  assign ocupado   = (estado_reg == EXEC) || (estado_reg == ITERA);
  assign pronto    = pronto_reg;
  assign erro_div0 = erro_reg;

endmodule

// File: tb/tb_sequenciador_ula.sv
// Bench for sequenciador_ula: drives entry sequences, models the external ALU,
// and checks results against a queue of expected values.
module tb_sequenciador_ula;

  logic       clk = 1'b0;
  logic       rst;
  logic       enter;
  logic       reuso;
  logic [7:0] dado_in;
  logic [2:0] op_in;
  logic [7:0] alu_res;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] resultado;
  logic [2:0] estado;
  logic       ocupado;
  logic       pronto;
  logic       erro_div0;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  sequenciador_ula #(.W(8)) dut (
    .clk(clk), .rst(rst), .enter(enter), .reuso(reuso),
    .dado_in(dado_in), .op_in(op_in), .alu_res(alu_res),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .resultado(resultado), .estado(estado), .ocupado(ocupado),
    .pronto(pronto), .erro_div0(erro_div0)
  );

  always #5 clk = ~clk;

  // external combinational ALU
  always_comb begin
    case (alu_op)
      3'b000:  alu_res = alu_a + alu_b;
      3'b001:  alu_res = alu_a - alu_b;
      3'b010:  alu_res = alu_a & alu_b;
      3'b011:  alu_res = alu_a | alu_b;
      3'b100:  alu_res = alu_a ^ alu_b;
      default: alu_res = ~alu_a;
    endcase
  end

  task automatic pulse(input logic e, input logic r, input logic [7:0] d, input logic [2:0] o);
    @(negedge clk);
    enter = e; reuso = r; dado_in = d; op_in = o;
    @(negedge clk);
    enter = 1'b0; reuso = 1'b0;
  endtask

  task automatic enter_seq(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
    pulse(1'b1, 1'b0, a, 3'd0);
    pulse(1'b1, 1'b0, b, 3'd0);
    pulse(1'b1, 1'b0, 8'd0, o);
  endtask

  // called right after the opcode pulse; returns at the negedge where pronto is high
  task automatic wait_done(output int busy, output bit got);
    busy = 0; got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (pronto) begin got = 1'b1; break; end
      if (ocupado) busy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; enter = 1'b0; reuso = 1'b0; dado_in = '0; op_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({resultado, alu_a, alu_b, alu_op, estado, ocupado, pronto, erro_div0} !== '0) begin
      n_err++;
      $display("FAIL reset: res=%h a=%h b=%h op=%0d st=%0d busy=%b pr=%b e=%b, required all 0",
               resultado, alu_a, alu_b, alu_op, estado, ocupado, pronto, erro_div0);
    end
    $display("reset: res=%h st=%0d", resultado, estado);
  endtask

  task automatic test_op(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] o, input logic [7:0] expv, input int exp_busy);
    int busy; bit got; logic [7:0] e;
    exp_q.push_back(expv);
    enter_seq(a, b, o);
    wait_done(busy, got);
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_timeout: pronto never seen, required pronto", name);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (resultado !== e) begin
      n_err++;
      $display("FAIL %s_result: got %h, required %h", name, resultado, e);
    end
    n_cmp++;
    if (busy != exp_busy) begin
      n_err++;
      $display("FAIL %s_busy: got %0d cycles, required %0d", name, busy, exp_busy);
    end
    n_cmp++;
    if (estado !== 3'd5) begin
      n_err++;
      $display("FAIL %s_state: got %0d, required 5", name, estado);
    end
    @(negedge clk);
    n_cmp++;
    if (pronto !== 1'b0) begin
      n_err++;
      $display("FAIL %s_pronto_width: pronto still %b, required 0", name, pronto);
    end
    $display("%s: a=%0d b=%0d op=%b res=%h busy=%0d", name, a, b, o, resultado, busy);
  endtask

  task automatic leave_mostra;
    pulse(1'b1, 1'b0, 8'h00, 3'd0);
  endtask

  task automatic test_basic;
    test_op("add", 8'd5, 8'd3, 3'b000, 8'd8, 1);
    leave_mostra();
    n_cmp++;
    if (estado !== 3'd0 || alu_a !== 8'd0 || resultado !== 8'd8) begin
      n_err++;
      $display("FAIL mostra_exit: st=%0d a=%h res=%h, required st=0 a=00 res=08", estado, alu_a, resultado);
    end
    test_op("and", 8'hF0, 8'h3C, 3'b010, 8'h30, 1); leave_mostra();
    test_op("or",  8'hF0, 8'h3C, 3'b011, 8'hFC, 1); leave_mostra();
    test_op("xor", 8'hF0, 8'h3C, 3'b100, 8'hCC, 1); leave_mostra();
  endtask

  task automatic test_mul;
    test_op("mul_12x11", 8'd12, 8'd11, 3'b110, 8'h84, 8); leave_mostra();
    test_op("mul_20x20", 8'd20, 8'd20, 3'b110, 8'h90, 8); leave_mostra();
  endtask

  task automatic test_div;
    test_op("div_200_7", 8'd200, 8'd7, 3'b111, 8'd28, 8);
    n_cmp++;
    if (erro_div0 !== 1'b0) begin
      n_err++;
      $display("FAIL div_flag: erro_div0=%b, required 0", erro_div0);
    end
    leave_mostra();
    test_op("div_255_16", 8'd255, 8'd16, 3'b111, 8'd15, 8); leave_mostra();
    test_op("div0", 8'd9, 8'd0, 3'b111, 8'hFF, 1);
    n_cmp++;
    if (erro_div0 !== 1'b1) begin
      n_err++;
      $display("FAIL div0_flag: erro_div0=%b, required 1", erro_div0);
    end
    leave_mostra();
    n_cmp++;
    if (erro_div0 !== 1'b0 || estado !== 3'd0) begin
      n_err++;
      $display("FAIL div0_clear: erro_div0=%b st=%0d, required 0/0", erro_div0, estado);
    end
  endtask

  task automatic test_reuse;
    test_op("chain_add", 8'd5, 8'd3, 3'b000, 8'd8, 1);
    pulse(1'b0, 1'b1, 8'h77, 3'd0);
    n_cmp++;
    if (alu_a !== 8'd8 || estado !== 3'd1) begin
      n_err++;
      $display("FAIL reuse_mostra: a=%h st=%0d, required a=08 st=1", alu_a, estado);
    end
    pulse(1'b1, 1'b0, 8'd2, 3'd0);
    begin
      int busy; bit got; logic [7:0] e;
      exp_q.push_back(8'd6);
      pulse(1'b1, 1'b0, 8'd0, 3'b001);
      wait_done(busy, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got || resultado !== e) begin
        n_err++;
        $display("FAIL reuse_sub: got %h, required %h", resultado, e);
      end
      $display("reuse_sub: res=%h", resultado);
    end
    leave_mostra();
    pulse(1'b1, 1'b1, 8'h33, 3'd0);
    n_cmp++;
    if (alu_a !== 8'd6 || estado !== 3'd1) begin
      n_err++;
      $display("FAIL reuse_priority: a=%h st=%0d, required a=06 st=1", alu_a, estado);
    end
    begin
      int busy; bit got; logic [7:0] e;
      exp_q.push_back(8'd10);
      pulse(1'b1, 1'b0, 8'd4, 3'd0);
      pulse(1'b1, 1'b0, 8'd0, 3'b000);
      wait_done(busy, got);
      e = exp_q.pop_front();
      n_cmp++;
      if (!got || resultado !== e) begin
        n_err++;
        $display("FAIL reuse_add: got %h, required %h", resultado, e);
      end
      $display("reuse_add: res=%h", resultado);
    end
    leave_mostra();
  endtask

  task automatic test_busy;
    int busy; bit got; logic [7:0] e;
    busy = 0; got = 1'b0;
    exp_q.push_back(8'h01);
    enter_seq(8'd255, 8'd255, 3'b110);
    for (int n = 0; n < 100; n++) begin
      if (pronto) begin got = 1'b1; enter = 1'b0; reuso = 1'b0; break; end
      if (ocupado) begin
        busy++;
        if (estado !== 3'd4) begin
          n_cmp++; n_err++;
          $display("FAIL busy_state: st=%0d during ITERA, required 4", estado);
        end
      end
      enter = ocupado; reuso = ocupado; dado_in = 8'h55;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!got || resultado !== e || busy != 8) begin
      n_err++;
      $display("FAIL busy_mul: res=%h busy=%0d, required %h busy=8", resultado, busy, e);
    end
    n_cmp++;
    if (alu_a !== 8'hFF || alu_b !== 8'hFF || estado !== 3'd5) begin
      n_err++;
      $display("FAIL busy_regs: a=%h b=%h st=%0d, required ff ff 5", alu_a, alu_b, estado);
    end
    $display("busy_mul: res=%h busy=%0d", resultado, busy);
    leave_mostra();
  endtask

  task automatic test_reset_mid;
    bit saw_pronto;
    enter_seq(8'd12, 8'd11, 3'b110);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({resultado, alu_a, alu_b, alu_op, estado, ocupado, pronto, erro_div0} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: res=%h a=%h b=%h st=%0d busy=%b pr=%b, required all 0",
               resultado, alu_a, alu_b, estado, ocupado, pronto);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_pronto = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (pronto) saw_pronto = 1'b1;
    end
    n_cmp++;
    if (saw_pronto || estado !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid_pronto: pronto=%b st=%0d, required 0/0", saw_pronto, estado);
    end
    $display("reset_mid: st=%0d", estado);
    test_op("after_reset_sub", 8'd7, 8'd2, 3'b001, 8'd5, 1);
    leave_mostra();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mul();
    test_div();
    test_reuse();
    test_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
